// File: rtl/dircc_avalon_st_pkg.sv
// Shared definitions for the Avalon-ST packet source: CSR map, bit indices, FSM states.
package dircc_avalon_st_pkg;

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_LENGTH  = 2'd1;
  localparam logic [1:0] ADDR_SEED    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int STAT_BUSY    = 15;
  localparam int STAT_LEN_ERR = 14;
  localparam int STAT_ABORTED = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/dircc_avalon_st_packet_source_if.sv
// Stream source + CSR slave signal bundle. master = packet source view, slave = sink/CPU view.
interface dircc_avalon_st_packet_source_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   endofpacket;
  logic                   startofpacket;
  logic                   valid;
  logic                   ready;
  logic [1:0]             address;
  logic                   read_n;
  logic                   write_n;
  logic [15:0]            writedata;
  logic [15:0]            readdata;

  modport master (
    output data, empty, endofpacket, startofpacket, valid, readdata,
    input  ready, address, read_n, write_n, writedata
  );

  modport slave (
    input  data, empty, endofpacket, startofpacket, valid, readdata,
    output ready, address, read_n, write_n, writedata
  );
endinterface

// File: rtl/dircc_avalon_st_packet_source_csr.sv
// CSR block: LENGTH/SEED registers, sticky status flags, packet counter and registered readdata.
module dircc_avalon_st_packet_source_csr
  import dircc_avalon_st_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  address_i,
  input  logic        read_n_i,
  input  logic        write_n_i,
  input  logic [15:0] writedata_i,
  output logic [15:0] readdata_o,
  input  logic        busy_i,
  input  logic        len_err_set_i,
  input  logic        aborted_set_i,
  input  logic        pkt_done_i,
  output logic        start_o,
  output logic        abort_o,
  output logic [15:0] length_o,
  output logic [15:0] seed_o
);

  logic [15:0] length_q, length_d;
  logic [15:0] seed_q, seed_d;
  logic        len_err_q, len_err_d;
  logic        aborted_q, aborted_d;
  logic [7:0]  pkt_cnt_q, pkt_cnt_d;
  logic [15:0] readdata_q, readdata_d;
  logic        wr_ctrl, clear;
  logic [15:0] status_w;

  // Abort takes priority over start within one CONTROL write.
  assign wr_ctrl  = !write_n_i && (address_i == ADDR_CONTROL);
  assign start_o  = wr_ctrl && writedata_i[CTRL_START] && !writedata_i[CTRL_ABORT];
  assign abort_o  = wr_ctrl && writedata_i[CTRL_ABORT];
  assign clear    = wr_ctrl && writedata_i[CTRL_CLEAR];
  assign status_w = {busy_i, len_err_q, aborted_q, 5'b0, pkt_cnt_q};

  // Next-state for registers and flags; clear is applied first so a same-cycle event survives.
  always_comb begin
    length_d   = length_q;
    seed_d     = seed_q;
    len_err_d  = len_err_q;
    aborted_d  = aborted_q;
    pkt_cnt_d  = pkt_cnt_q;
    readdata_d = readdata_q;
    if (!write_n_i && !busy_i) begin
      if (address_i == ADDR_LENGTH) length_d = writedata_i;
      if (address_i == ADDR_SEED)   seed_d   = writedata_i;
    end
    if (clear) begin
      len_err_d = 1'b0;
      aborted_d = 1'b0;
      pkt_cnt_d = 8'd0;
    end
    if (len_err_set_i) len_err_d = 1'b1;
    if (aborted_set_i) aborted_d = 1'b1;
    if (pkt_done_i)    pkt_cnt_d = pkt_cnt_d + 8'd1;
    if (!read_n_i) begin
      case (address_i)
        ADDR_LENGTH: readdata_d = length_q;
        ADDR_SEED:   readdata_d = seed_q;
        ADDR_STATUS: readdata_d = status_w;
        default:     readdata_d = 16'd0;
      endcase
    end
  end

  // CSR state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      length_q   <= 16'd0;
      seed_q     <= 16'd0;
      len_err_q  <= 1'b0;
      aborted_q  <= 1'b0;
      pkt_cnt_q  <= 8'd0;
      readdata_q <= 16'd0;
    end else begin
      length_q   <= length_d;
      seed_q     <= seed_d;
      len_err_q  <= len_err_d;
      aborted_q  <= aborted_d;
      pkt_cnt_q  <= pkt_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata_o = readdata_q;
  assign length_o   = length_q;
  assign seed_o     = seed_q;

endmodule

// File: rtl/dircc_avalon_st_packet_source.sv
// Avalon-ST packet generator: incrementing payload from SEED, LENGTH bytes, CSR-controlled.
module dircc_avalon_st_packet_source
  import dircc_avalon_st_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  parameter int MAX_LEN     = 16'hFFFF
) (
  input  logic clk,
  input  logic reset,
  dircc_avalon_st_packet_source_if.master bus
);

  localparam int BPB = DATA_WIDTH / 8;

  state_e                 state_q, state_d;
  logic [16:0]            beats_q, beats_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [EMPTY_WIDTH-1:0] empty_q, empty_d;
  logic [EMPTY_WIDTH-1:0] eop_empty_q, eop_empty_d;
  logic                   abort_pend_q, abort_pend_d;

  logic        start, abort, pkt_done, len_err_set, aborted_set, accept, len_ok;
  logic [15:0] length, seed;
  logic [16:0] len_ext, beats_calc, rem;
  logic [EMPTY_WIDTH-1:0] empty_calc;

  dircc_avalon_st_packet_source_csr u_csr (
    .clk_i         (clk),
    .rst_i         (reset),
    .address_i     (bus.address),
    .read_n_i      (bus.read_n),
    .write_n_i     (bus.write_n),
    .writedata_i   (bus.writedata),
    .readdata_o    (bus.readdata),
    .busy_i        (state_q == SEND),
    .len_err_set_i (len_err_set),
    .aborted_set_i (aborted_set),
    .pkt_done_i    (pkt_done),
    .start_o       (start),
    .abort_o       (abort),
    .length_o      (length),
    .seed_o        (seed)
  );

  // Packet geometry derived from the programmed byte length.
  assign len_ext    = {1'b0, length};
  assign len_ok     = (length != 16'd0) && (len_ext <= 17'(MAX_LEN));
  assign beats_calc = (len_ext + 17'(BPB - 1)) / 17'(BPB);
  assign rem        = len_ext % 17'(BPB);
  assign empty_calc = EMPTY_WIDTH'((17'(BPB) - rem) % 17'(BPB));
  assign accept     = valid_q && bus.ready;

  // FSM next-state and beat generation. Outputs are registered so they hold while stalled.
  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    data_d       = data_q;
    valid_d      = valid_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    empty_d      = empty_q;
    eop_empty_d  = eop_empty_q;
    abort_pend_d = abort_pend_q;
    pkt_done     = 1'b0;
    len_err_set  = 1'b0;
    aborted_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d      = SEND;
            beats_d      = beats_calc;
            data_d       = DATA_WIDTH'(seed);
            valid_d      = 1'b1;
            sop_d        = 1'b1;
            eop_d        = (beats_calc == 17'd1);
            empty_d      = (beats_calc == 17'd1) ? empty_calc : '0;
            eop_empty_d  = empty_calc;
            abort_pend_d = 1'b0;
          end else begin
            len_err_set = 1'b1;
          end
        end
      end
      SEND: begin
        // Abort closes the packet on the next beat presented, leaving the current beat untouched.
        if (abort) begin
          aborted_set  = 1'b1;
          abort_pend_d = 1'b1;
        end
        if (accept) begin
          if (eop_q) begin
            state_d      = IDLE;
            valid_d      = 1'b0;
            sop_d        = 1'b0;
            eop_d        = 1'b0;
            empty_d      = '0;
            abort_pend_d = 1'b0;
            pkt_done     = 1'b1;
          end else begin
            beats_d = beats_q - 17'd1;
            data_d  = data_q + DATA_WIDTH'(1);
            sop_d   = 1'b0;
            if (abort || abort_pend_q) begin
              eop_d   = 1'b1;
              empty_d = '0;
            end else begin
              eop_d   = (beats_q == 17'd2);
              empty_d = (beats_q == 17'd2) ? eop_empty_q : '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and stream output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_q      <= 17'd0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      empty_q      <= '0;
      eop_empty_q  <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      empty_q      <= empty_d;
      eop_empty_q  <= eop_empty_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign bus.data          = data_q;
  assign bus.valid         = valid_q;
  assign bus.startofpacket = sop_q;
  assign bus.endofpacket   = eop_q;
  assign bus.empty         = empty_q;

endmodule

// File: doc/dircc_avalon_st_packet_source.md
Name: dircc_avalon_st_packet_source

Overview:
- Avalon-ST packet generator that drives the data/valid/sop/eop/empty sink interface of the processing-counter test terminal directly upstream.
- A small Avalon-MM slave lets the CPU/bench program a byte length and a seed, then issue start.
- Payload is an incrementing word sequence starting at the seed.
- Lets us exercise the terminal's error flag and backpressure paths with well-formed packets.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; multiple of 8.
- EMPTY_WIDTH, 2, width of empty; must hold log2(DATA_WIDTH/8).
- MAX_LEN, 16'hFFFF, largest accepted byte length; longer values are rejected.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- data  out  DATA_WIDTH  stream payload.
- empty  out  EMPTY_WIDTH  unused bytes in the eop beat.
- endofpacket  out  1  last beat of packet.
- startofpacket  out  1  first beat of packet.
- valid  out  1  beat valid.
- ready  in  1  sink ready, readyLatency 0.
- address  in  2  CSR address.
- read_n  in  1  active-low CSR read strobe.
- write_n  in  1  active-low CSR write strobe.
- writedata  in  16  CSR write data.
- readdata  out  16  CSR read data, registered.

Behaviour:
- Reset (async, active-high): clear all outputs (valid, startofpacket, endofpacket, data, empty, readdata), LENGTH, SEED, status flags and PKT_CNT. FSM goes to IDLE.
- CSR map:
  - 0 CONTROL: write-only. Bit0 start, bit1 abort, bit2 clear_status. Reads return 0.
  - 1 LENGTH: R/W, bytes.
  - 2 SEED: R/W, first data word (zero-extended).
  - 3 STATUS: read-only. Bit15 busy, bit14 len_err, bit13 aborted, bits7:0 PKT_CNT (wraps at 255 to 0).
- readdata updates the cycle after read_n is sampled low. When read_n is high it holds its last value.
- Beats per packet: BEATS = ceil(LENGTH / BPB), where BPB = DATA_WIDTH/8. Eop-beat empty = (BPB - LENGTH mod BPB) mod BPB.
- FSM states: IDLE, SEND.
- IDLE:
  - start with 1 <= LENGTH <= MAX_LEN: load beat counter with BEATS and the data word with SEED, then enter SEND. valid rises the next cycle, with startofpacket=1.
  - start with LENGTH = 0 or LENGTH > MAX_LEN: set len_err, stay in IDLE, emit no beat.
- SEND:
  - data/sop/eop/empty hold stable while valid & !ready.
  - On valid & ready: decrement beat counter, data += 1, startofpacket goes to 0.
  - endofpacket=1 exactly when the remaining count is 1. empty is driven only on that beat, 0 otherwise.
  - When the eop beat is accepted: valid falls the next cycle, PKT_CNT += 1, return to IDLE.
  - Back-to-back packets: a new start is accepted only in IDLE, so there is a minimum 1-cycle gap between packets.
- start while busy: ignored. No flag is set.
- Writes to LENGTH or SEED while busy: ignored.
- Abort in SEND: the next presented beat is forced to endofpacket=1, empty=0. Set aborted. Finish normally on acceptance so the packet is always closed.
- Abort in IDLE: no effect.
- Simultaneous start and abort in the same write: abort wins, no packet.
- Simultaneous clear_status and a new event in the same cycle: the new event wins.
- Single-beat packet (LENGTH <= BPB): sop=eop=1 on the same beat.
- Reset mid-packet: valid drops immediately (async). No eop is emitted, and the downstream tolerates this.

Decomposition:
- Shared package dircc_avalon_st_pkg:
  - CSR address constants: ADDR_CONTROL, ADDR_LENGTH, ADDR_SEED, ADDR_STATUS.
  - CONTROL and STATUS bit-index constants.
  - FSM state enum: IDLE, SEND.
- One natural sub-module, dircc_avalon_st_packet_source_csr: register file plus readdata mux. It drives a start/abort pulse and length/seed into the FSM/datapath in the top module.

Test Plan:
- LENGTH=12, SEED=5, start, ready=1 → 3 beats, data 5,6,7; sop on beat 1, eop on beat 3; empty=0; PKT_CNT=1; busy then idle.
- LENGTH=6, ready toggling 1/0 every cycle → 2 beats; data/eop stable while stalled; final beat empty=2; valid low the cycle after acceptance.
- LENGTH=3 → single beat with sop=eop=1, empty=1; feed to downstream terminal → its status reads 16'h8000.
- LENGTH=0, start → len_err set, valid never asserts. Write clear_status → STATUS=0.
- LENGTH=40, abort after 2 accepted beats → 3rd beat has eop=1, empty=0; aborted=1; start during SEND ignored.
- Assert reset mid-packet → valid, sop, eop, readdata are 0 immediately. After release, STATUS reads 0 and the next start sends a fresh packet.
